// File: rtl/dual_port_memory.sv
// Two-port word memory: port A reads/writes, port B is read-only, both single-cycle acked.
// An optional zero-fill sweep runs after reset; out-of-range accesses raise a sticky fault.
`default_nettype none

module dual_port_memory #(
    parameter int MEM_SIZE       = 4096,
    parameter int WORD_SIZE      = 20,
    parameter int ADDR_WIDTH     = 16,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req_i,
    input  logic                  a_write_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WORD_SIZE-1:0]  a_value_i,
    output logic                  a_ack_o,
    output logic [WORD_SIZE-1:0]  a_value_o,
    input  logic                  b_req_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic                  b_ack_o,
    output logic [WORD_SIZE-1:0]  b_value_o,
    output logic                  ready_o,
    input  logic                  fault_clr_i,
    output logic                  fault_o,
    output logic [ADDR_WIDTH-1:0] fault_addr_o
);

    localparam int                  IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH     = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [WORD_SIZE-1:0]    mem [MEM_SIZE];

    logic                    a_acc;
    logic                    b_acc;
    logic                    a_oor;
    logic                    b_oor;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        b_idx;
    logic                    a_wr;
    logic                    collide;
    logic [WORD_SIZE-1:0]    a_rd_word;
    logic [WORD_SIZE-1:0]    b_rd_word;
    logic                    a_fault;
    logic                    b_fault;
    logic [ADDR_WIDTH-1:0]   fault_src;

    // Requests are only honoured once the sweep has finished.
    assign a_acc   = a_req_i & ready_o;
    assign b_acc   = b_req_i & ready_o;
    assign a_oor   = ({1'b0, a_addr_i} >= DEPTH);
    assign b_oor   = ({1'b0, b_addr_i} >= DEPTH);
    assign a_idx   = a_addr_i[IDX_W-1:0];
    assign b_idx   = b_addr_i[IDX_W-1:0];
    assign a_wr    = a_acc & a_write_i & ~a_oor;
    assign collide = a_wr & b_acc & ~b_oor & (a_addr_i == b_addr_i);

    assign a_rd_word = a_oor ? '0
                     : ((WRITE_FIRST != 0) && a_write_i) ? a_value_i
                     : mem[a_idx];
    assign b_rd_word = b_oor ? '0
                     : ((WRITE_FIRST != 0) && collide) ? a_value_i
                     : mem[b_idx];

    assign a_fault   = a_acc & a_oor;
    assign b_fault   = b_acc & b_oor;
    assign fault_src = a_fault ? a_addr_i : b_addr_i;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_cnt <= '0;
            ready_o <= 1'b0;
        end else begin
            state   <= state_next;
            ready_o <= (state_next == RUN);
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // The array itself is never reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt[IDX_W-1:0]] <= '0;
        else if (a_wr)
            mem[a_idx] <= a_value_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_ack_o   <= 1'b0;
            b_ack_o   <= 1'b0;
            a_value_o <= '0;
            b_value_o <= '0;
        end else begin
            a_ack_o <= a_acc;
            b_ack_o <= b_acc;
            if (a_acc) a_value_o <= a_rd_word;
            if (b_acc) b_value_o <= b_rd_word;
        end
    end

    // A fresh fault beats a simultaneous clear; otherwise only the first fault is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
        end else if ((a_fault | b_fault) && (fault_clr_i || !fault_o)) begin
            fault_o      <= 1'b1;
            fault_addr_o <= fault_src;
        end else if (fault_clr_i) begin
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dual_port_memory.sv
// Directed bench for dual_port_memory with a 16-word array, read-first and write-first instances.
`default_nettype none

module tb_dual_port_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req_i, a_write_i, b_req_i, fault_clr_i;
    logic [15:0] a_addr_i, b_addr_i;
    logic [19:0] a_value_i;

    logic        a_ack_o, b_ack_o, ready_o, fault_o;
    logic [19:0] a_value_o, b_value_o;
    logic [15:0] fault_addr_o;

    logic        wf_a_ack, wf_b_ack, wf_ready, wf_fault;
    logic [19:0] wf_a_value, wf_b_value;
    logic [15:0] wf_fault_addr;

    int errors = 0;
    int checks = 0;

    logic [19:0] mdl [16];
    logic [19:0] exp_av, exp_bv, exp_wf_av, exp_wf_bv;
    logic        exp_f;
    logic [15:0] exp_fa;

    always #5 clk = ~clk;

    dual_port_memory #(
        .MEM_SIZE(16), .WORD_SIZE(20), .ADDR_WIDTH(16), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .a_req_i(a_req_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i), .a_value_i(a_value_i),
        .a_ack_o(a_ack_o), .a_value_o(a_value_o),
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_ack_o(b_ack_o), .b_value_o(b_value_o),
        .ready_o(ready_o), .fault_clr_i(fault_clr_i), .fault_o(fault_o), .fault_addr_o(fault_addr_o)
    );

    dual_port_memory #(
        .MEM_SIZE(16), .WORD_SIZE(20), .ADDR_WIDTH(16), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) u_dut_wf (
        .clk(clk), .reset_n(reset_n),
        .a_req_i(a_req_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i), .a_value_i(a_value_i),
        .a_ack_o(wf_a_ack), .a_value_o(wf_a_value),
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_ack_o(wf_b_ack), .b_value_o(wf_b_value),
        .ready_o(wf_ready), .fault_clr_i(fault_clr_i), .fault_o(wf_fault), .fault_addr_o(wf_fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_req_i = 1'b0; a_write_i = 1'b0; a_addr_i = '0; a_value_i = '0;
        b_req_i = 1'b0; b_addr_i = '0; fault_clr_i = 1'b0;
    endtask

    // Counts edges after reset release until ready rises, flagging any ack or fault seen meanwhile.
    task automatic wait_ready(output int n, output logic saw);
        n = 0;
        saw = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (a_ack_o || b_ack_o || fault_o || wf_a_ack || wf_b_ack) saw = 1'b1;
        end while (!ready_o && n < 100);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        exp_av = '0; exp_bv = '0; exp_wf_av = '0; exp_wf_bv = '0;
        exp_f = 1'b0; exp_fa = '0;
    endtask

    // One clock of traffic: drive, predict, clock, then compare every output.
    task automatic op(input logic ar, input logic aw, input logic [15:0] aa, input logic [19:0] av,
                      input logic br, input logic [15:0] ba, input logic fc);
        logic a_oor, b_oor, newf;
        logic [15:0] fa;
        a_req_i = ar; a_write_i = aw; a_addr_i = aa; a_value_i = av;
        b_req_i = br; b_addr_i = ba; fault_clr_i = fc;
        a_oor = (aa >= 16'd16);
        b_oor = (ba >= 16'd16);
        if (ar) begin
            exp_av    = a_oor ? 20'h0 : mdl[aa[3:0]];
            exp_wf_av = a_oor ? 20'h0 : (aw ? av : mdl[aa[3:0]]);
        end
        if (br) begin
            exp_bv    = b_oor ? 20'h0 : mdl[ba[3:0]];
            exp_wf_bv = b_oor ? 20'h0 : ((ar && aw && !a_oor && aa == ba) ? av : mdl[ba[3:0]]);
        end
        newf = (ar && a_oor) || (br && b_oor);
        fa   = (ar && a_oor) ? aa : ba;
        if (fc) begin
            exp_f  = newf;
            exp_fa = newf ? fa : 16'h0;
        end else if (!exp_f && newf) begin
            exp_f  = 1'b1;
            exp_fa = fa;
        end
        @(posedge clk); #1;
        if (ar && aw && !a_oor) mdl[aa[3:0]] = av;
        check("a_ack", a_ack_o, ar);
        check("b_ack", b_ack_o, br);
        check("a_value", a_value_o, exp_av);
        check("b_value", b_value_o, exp_bv);
        check("fault", fault_o, exp_f);
        check("fault_addr", fault_addr_o, exp_fa);
        check("wf_a_value", wf_a_value, exp_wf_av);
        check("wf_b_value", wf_b_value, exp_wf_bv);
    endtask

    initial begin
        int   n;
        logic saw;

        idle_inputs();
        model_clear();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_o, 1'b0);
        check("rst_a_ack", a_ack_o, 1'b0);
        check("rst_fault", fault_o, 1'b0);
        check("rst_a_value", a_value_o, 20'h0);
        check("rst_fault_addr", fault_addr_o, 16'h0);

        // Requests held high during the sweep must be ignored entirely.
        a_req_i = 1'b1; a_write_i = 1'b1; a_addr_i = 16'd2; a_value_i = 20'hFFFFF;
        b_req_i = 1'b1; b_addr_i = 16'd20;
        reset_n = 1'b1;
        wait_ready(n, saw);
        check("sweep_cycles", n, 16);
        check("sweep_no_ack", saw, 1'b0);
        check("wf_ready", wf_ready, 1'b1);

        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 16'(i), 20'h0, 1'b1, 16'(15 - i), 1'b0);

        op(1'b1, 1'b1, 16'd3, 20'h12345, 1'b0, 16'd0, 1'b0);
        op(1'b1, 1'b0, 16'd3, 20'h0, 1'b1, 16'd3, 1'b0);
        op(1'b1, 1'b1, 16'd5, 20'h00001, 1'b0, 16'd0, 1'b0);
        op(1'b1, 1'b1, 16'd5, 20'hABCDE, 1'b1, 16'd5, 1'b0);
        op(1'b0, 1'b0, 16'd0, 20'h0, 1'b0, 16'd0, 1'b0);
        op(1'b1, 1'b0, 16'd5, 20'h0, 1'b1, 16'd3, 1'b0);

        op(1'b1, 1'b0, 16'd20, 20'h0, 1'b0, 16'd0, 1'b0);
        op(1'b0, 1'b0, 16'd0, 20'h0, 1'b1, 16'd30, 1'b0);
        op(1'b0, 1'b0, 16'd0, 20'h0, 1'b0, 16'd0, 1'b1);
        op(1'b1, 1'b0, 16'd17, 20'h0, 1'b1, 16'd40, 1'b0);
        op(1'b1, 1'b1, 16'd16, 20'h55555, 1'b1, 16'd25, 1'b1);
        op(1'b1, 1'b0, 16'd0, 20'h0, 1'b0, 16'd0, 1'b1);

        for (int i = 0; i < 8; i++)
            op(1'b1, (i % 2) == 0, 16'(i + 8), 20'h100 + 20'(i), 1'b1, 16'((i + 7) % 16), 1'b0);
        op(1'b0, 1'b0, 16'd0, 20'h0, 1'b0, 16'd0, 1'b0);

        // Reset mid-stream, then again partway through the sweep.
        a_req_i = 1'b1; b_req_i = 1'b1; a_addr_i = 16'd3; b_addr_i = 16'd5;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("async_a_ack", a_ack_o, 1'b0);
        check("async_b_value", b_value_o, 20'h0);
        check("async_ready", ready_o, 1'b0);
        #2 reset_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        wait_ready(n, saw);
        check("resweep_cycles", n, 16);
        check("resweep_no_ack", saw, 1'b0);

        model_clear();
        op(1'b1, 1'b0, 16'd3, 20'h0, 1'b1, 16'd5, 1'b0);
        op(1'b1, 1'b0, 16'd8, 20'h0, 1'b1, 16'd10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
